mem_responder: RTL and testbench

- Data-memory responder at the far end of the mem-access stage's memory interface.
- Services same-cycle combinational reads and posted writes.
- Writes are held in a small posted-write buffer, drained into a single-write-port word array during idle bus cycles.
- Reads forward from the buffer so the pipeline always sees the newest data; buffer-full status is reported back as a stall.

---
 rtl/mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - data-memory responder with optional posted-write buffer (MEM_RESP_WBUF_EN)
module mem_responder #(
  parameter int DEPTH_W    = 12,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_async_n,
  input  logic                          mem_access_active,
  input  logic                          mem_write_enable,
  input  logic [19:0]                   mem_address,
  input  logic [31:0]                   mem_write_value,
  output logic [31:0]                   mem_read_value,
  output logic                          mem_stall,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
  output logic                          mem_error
);

  localparam int WORDS = 1 << DEPTH_W;

  logic               is_load;
  logic               is_store;
  logic               in_range;
  logic [DEPTH_W-1:0] idx;
  logic [31:0]        mem_q [WORDS];
  logic               error_q;
  logic               error_d;

  assign is_load  = mem_access_active & ~mem_write_enable;
  assign is_store = mem_access_active & mem_write_enable;
  assign in_range = (mem_address[19:DEPTH_W] == '0);
  assign idx      = mem_address[DEPTH_W-1:0];

`ifdef MEM_RESP_WBUF_EN
  localparam int                PTR_W    = $clog2(WBUF_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(WBUF_DEPTH);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W-1:0] wb_idx_q  [WBUF_DEPTH];
  logic [31:0]        wb_data_q [WBUF_DEPTH];
  logic               is_idle;
  logic               enq;
  logic               drain;
  logic               fwd_hit;
  logic [31:0]        fwd_data;
  logic [PTR_W-1:0]   fwd_ptr;

  assign is_idle = ~mem_access_active;

  // Forwarding scan runs oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_ptr  = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      fwd_ptr = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (wb_idx_q[fwd_ptr] == idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[fwd_ptr];
      end
    end
  end

  // Load data: buffer first, array otherwise; zero for anything that is not an in-range load.
  always_comb begin
    mem_read_value = '0;
    if (is_load && in_range) mem_read_value = fwd_hit ? fwd_data : mem_q[idx];
  end

  // Buffer occupancy FSM: decides enqueue/drain and tracks count, pointers and error.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    error_d  = error_q;
    enq      = 1'b0;
    drain    = 1'b0;
    if ((is_load || is_store) && !in_range) error_d = 1'b1;
    case (state_q)
      ST_EMPTY:   if (is_store && in_range) enq = 1'b1;
      ST_PARTIAL: begin
        if (is_store && in_range) enq = 1'b1;
        else if (is_idle)         drain = 1'b1;
      end
      ST_FULL: begin
        if (is_store)     error_d = 1'b1;
        else if (is_idle) drain = 1'b1;
      end
      default:    state_d = ST_EMPTY;
    endcase
    if (enq) begin
      count_d  = count_q + 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      state_d  = (count_q == FULL_CNT - 1'b1) ? ST_FULL : ST_PARTIAL;
    end
    if (drain) begin
      count_d  = count_q - 1'b1;
      rd_ptr_d = rd_ptr_q + 1'b1;
      state_d  = (count_q == CNT_W'(1)) ? ST_EMPTY : ST_PARTIAL;
    end
  end

  // Control state; a drain pending when reset hits is simply discarded.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Buffer and array storage are not reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_idx_q[wr_ptr_q]  <= idx;
      wb_data_q[wr_ptr_q] <= mem_write_value;
    end
    if (drain) mem_q[wb_idx_q[rd_ptr_q]] <= wb_data_q[rd_ptr_q];
  end

  assign mem_stall  = (count_q == FULL_CNT);
  assign wbuf_count = count_q;
`else
  // Load data straight from the array.
  always_comb begin
    mem_read_value = '0;
    if (is_load && in_range) mem_read_value = mem_q[idx];
  end

  // Out-of-range accesses make the error sticky.
  always_comb begin
    error_d = error_q;
    if ((is_load || is_store) && !in_range) error_d = 1'b1;
  end

  // In-range stores write the array directly; contents are not reset.
  always_ff @(posedge clk) begin
    if (is_store && in_range) mem_q[idx] <= mem_write_value;
  end

  assign mem_stall  = 1'b0;
  assign wbuf_count = '0;
`endif

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) error_q <= 1'b0;
    else              error_q <= error_d;
  end

  assign mem_error = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

`ifdef MEM_RESP_WBUF_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  localparam int K_RD  = 0;
  localparam int K_CNT = 1;
  localparam int K_STL = 2;
  localparam int K_ERR = 3;

  logic        clk = 1'b0;
  logic        rst_async_n;
  logic        mem_access_active;
  logic        mem_write_enable;
  logic [19:0] mem_address;
  logic [31:0] mem_write_value;
  logic [31:0] mem_read_value;
  logic        mem_stall;
  logic [2:0]  wbuf_count;
  logic        mem_error;

  mem_responder #(.DEPTH_W(12), .WBUF_DEPTH(4)) dut (
    .clk               (clk),
    .rst_async_n       (rst_async_n),
    .mem_access_active (mem_access_active),
    .mem_write_enable  (mem_write_enable),
    .mem_address       (mem_address),
    .mem_write_value   (mem_write_value),
    .mem_read_value    (mem_read_value),
    .mem_stall         (mem_stall),
    .wbuf_count        (wbuf_count),
    .mem_error         (mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation issued for the current cycle and compares mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_RD:    mon_act = mem_read_value;
        K_CNT:   mon_act = {29'd0, wbuf_count};
        K_STL:   mon_act = {31'd0, mem_stall};
        default: mon_act = {31'd0, mem_error};
      endcase
      checks++;
      if (mon_act !== mon_e.val) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", mon_e.name, mon_act, mon_e.val);
      end
    end
  end

  task automatic push_exp(input string n, input int k, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.name = n;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic act, input logic we, input logic [19:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    mem_access_active = act;
    mem_write_enable  = we;
    mem_address       = a;
    mem_write_value   = d;
  endtask

  task automatic st(input logic [19:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
  endtask

  task automatic ld(input logic [19:0] a);
    drive(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 20'h0, 32'h0);
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst_async_n       = 1'b0;
    mem_access_active = 1'b0;
    @(posedge clk);
    #1;
    rst_async_n = 1'b1;
  endtask

  initial begin
    rst_async_n       = 1'b0;
    mem_access_active = 1'b0;
    mem_write_enable  = 1'b0;
    mem_address       = '0;
    mem_write_value   = '0;
    repeat (2) @(posedge clk);
    #1 rst_async_n = 1'b1;

    idle();
    idle();
    push_exp("rst_stall", K_STL, 0);
    push_exp("rst_count", K_CNT, 0);
    push_exp("rst_error", K_ERR, 0);
    push_exp("rst_read",  K_RD,  0);

    st(20'h00010, 32'hDEADBEEF);
    ld(20'h00010);
    push_exp("fwd_read",  K_RD,  32'hDEADBEEF);
    push_exp("fwd_count", K_CNT, WB ? 1 : 0);
    idle();
    ld(20'h00010);
    push_exp("arr_read",  K_RD,  32'hDEADBEEF);
    push_exp("arr_count", K_CNT, 0);

    st(20'h5, 32'h1);
    st(20'h5, 32'h2);
    ld(20'h5);
    push_exp("young_read",  K_RD,  32'h2);
    push_exp("young_count", K_CNT, WB ? 2 : 0);
    idle();
    idle();
    ld(20'h5);
    push_exp("drained_read",  K_RD,  32'h2);
    push_exp("drained_count", K_CNT, 0);

    st(20'h4, 32'h44);
    idle();
    ld(20'h4);
    push_exp("pre4_read", K_RD, 32'h44);
    st(20'h0, 32'hA0);
    st(20'h1, 32'hA1);
    st(20'h2, 32'hA2);
    st(20'h3, 32'hA3);
    push_exp("cnt3_count", K_CNT, WB ? 3 : 0);
    push_exp("cnt3_stall", K_STL, 0);
    st(20'h4, 32'h99);
    push_exp("full_stall", K_STL, WB ? 1 : 0);
    push_exp("full_count", K_CNT, WB ? 4 : 0);
    push_exp("store_read", K_RD,  0);
    push_exp("full_error_before", K_ERR, 0);
    idle();
    push_exp("drop_error", K_ERR, WB ? 1 : 0);
    push_exp("drop_count", K_CNT, WB ? 4 : 0);
    idle();
    idle();
    idle();
    ld(20'h4);
    push_exp("drop_read",  K_RD,  WB ? 32'h44 : 32'h99);
    push_exp("empty_count", K_CNT, 0);
    push_exp("empty_stall", K_STL, 0);
    ld(20'h2);
    push_exp("order2_read", K_RD, 32'hA2);
    ld(20'h3);
    push_exp("order3_read", K_RD, 32'hA3);

    rst_pulse();
    push_exp("clr_error", K_ERR, 0);
    ld(20'h80000);
    push_exp("oor_read",   K_RD,  0);
    push_exp("oor_err_pre", K_ERR, 0);
    idle();
    push_exp("oor_error", K_ERR, 1);

    rst_pulse();
    st(20'h01005, 32'h77);
    push_exp("oor_st_err_pre", K_ERR, 0);
    idle();
    push_exp("oor_st_error", K_ERR, 1);
    push_exp("oor_st_count", K_CNT, 0);
    ld(20'h5);
    push_exp("oor_st_alias", K_RD, 32'h2);

    rst_pulse();
    st(20'h20, 32'h11);
    st(20'h21, 32'h22);
    ld(20'h80000);
    push_exp("pre_rst_read",  K_RD,  0);
    push_exp("pre_rst_count", K_CNT, WB ? 2 : 0);
    ld(20'h21);
    push_exp("pre_rst_fwd",   K_RD,  32'h22);
    push_exp("pre_rst_error", K_ERR, 1);
    push_exp("pre_rst_cnt2",  K_CNT, WB ? 2 : 0);
    @(posedge clk);
    #1;
    mem_access_active = 1'b0;
    #2;
    rst_async_n = 1'b0;
    push_exp("async_count", K_CNT, 0);
    push_exp("async_stall", K_STL, 0);
    push_exp("async_error", K_ERR, 0);
    @(posedge clk);
    #1 rst_async_n = 1'b1;

    st(20'h7, 32'hA5);
    ld(20'h7);
    push_exp("a5_read",  K_RD,  32'hA5);
    push_exp("a5_count", K_CNT, WB ? 1 : 0);
    idle();
    ld(20'h7);
    push_exp("a5_arr_read",  K_RD,  32'hA5);
    push_exp("a5_arr_count", K_CNT, 0);

    idle();
    idle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
